// File: rtl/pipe_run_pkg.sv
// Shared types and helpers for the run/halt supervisor.
package pipe_run_pkg;

   typedef enum logic [2:0] {IDLE, RST, RUN, DRAIN, DONE} run_state_t;

   // Saturating add; w is the live width of the result, up to 64 bits.
   function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                           input int unsigned w);
      logic [64:0] sum;
      logic [63:0] lim;
      lim = {64{1'b1}} >> (64 - w);
      sum = {1'b0, a} + {1'b0, b};
      return (sum > {1'b0, lim}) ? lim : sum[63:0];
   endfunction

endpackage

// File: rtl/hart_halt_detector.sv
// Per-hart halt detection: ecall or a run of LOOP_LIMIT retires at the same PC.
// halted_nxt/pass_nxt expose this cycle's post-update view so the top sees a halt without delay.
module hart_halt_detector #(
   parameter int XLEN       = 32,
   parameter int LOOP_LIMIT = 8
) (
   input  logic            dclk,
   input  logic            dreset_n,
   input  logic            clear,
   input  logic            enable,
   input  logic            retire_valid,
   input  logic [XLEN-1:0] retire_pc,
   input  logic            retire_ecall,
   input  logic [XLEN-1:0] retire_a0,
   output logic            halted,
   output logic            halted_nxt,
   output logic            pass_nxt
);
   localparam int LW = $clog2(LOOP_LIMIT + 1);

   logic [XLEN-1:0] last_pc;
   logic            pc_valid;
   logic [LW-1:0]   loop_cnt;
   logic [LW-1:0]   loop_nxt;
   logic            hart_pass;
   logic            fire;
   logic            hit;

   always_comb begin
      fire       = enable && retire_valid && !halted;
      loop_nxt   = (pc_valid && retire_pc == last_pc) ? loop_cnt + 1'b1 : LW'(1);
      hit        = fire && (retire_ecall || loop_nxt == LW'(LOOP_LIMIT));
      halted_nxt = halted || hit;
      pass_nxt   = hit ? (retire_a0 == '0) : hart_pass;
   end

   always_ff @(posedge dclk or negedge dreset_n) begin
      if (!dreset_n) begin
         last_pc   <= '0;
         pc_valid  <= 1'b0;
         loop_cnt  <= '0;
         halted    <= 1'b0;
         hart_pass <= 1'b0;
      end else if (clear) begin
         last_pc   <= '0;
         pc_valid  <= 1'b0;
         loop_cnt  <= '0;
         halted    <= 1'b0;
         hart_pass <= 1'b0;
      end else if (fire) begin
         last_pc   <= retire_pc;
         pc_valid  <= 1'b1;
         loop_cnt  <= loop_nxt;
         halted    <= halted_nxt;
         hart_pass <= pass_nxt;
      end
   end

endmodule

// File: rtl/pipe_run_controller.sv
// Run/halt supervisor: sequences core reset, counts RUN cycles and retirements,
// waits for every hart to halt (or the cycle budget to expire), drains, then reports.
//
//   state | meaning
//   IDLE  | after reset, cores held in reset, waiting for start
//   RST   | cores held in reset for RST_CYCLES
//   RUN   | cores running, counting, watching for halts
//   DRAIN | all harts halted, pipeline drains for DRAIN_CYCLES
//   DONE  | results valid, cores back in reset, start re-arms
import pipe_run_pkg::*;

module pipe_run_controller #(
   parameter int XLEN         = 32,
   parameter int NUM_HARTS    = 1,
   parameter int RST_CYCLES   = 2,
   parameter int MAX_CYCLES   = 400,
   parameter int LOOP_LIMIT   = 8,
   parameter int DRAIN_CYCLES = 5,
   parameter int CNT_W        = 32
) (
   input  logic                      dclk,
   input  logic                      dreset_n,
   input  logic                      start,
   input  logic [NUM_HARTS-1:0]      retire_valid,
   input  logic [NUM_HARTS*XLEN-1:0] retire_pc,
   input  logic [NUM_HARTS-1:0]      retire_ecall,
   input  logic [NUM_HARTS*XLEN-1:0] retire_a0,
   output logic                      core_rst_n,
   output logic                      running,
   output logic                      done,
   output logic                      pass,
   output logic                      timeout,
   output logic [CNT_W-1:0]          cycle_count,
   output logic [CNT_W-1:0]          retire_count
);
   localparam int TMAX       = (RST_CYCLES > DRAIN_CYCLES) ? RST_CYCLES : DRAIN_CYCLES;
   localparam int TW         = $clog2(TMAX + 1);
   localparam int DRAIN_LOAD = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;

   run_state_t           state;
   logic [TW-1:0]        tmr;
   logic [NUM_HARTS-1:0] halted;
   logic [NUM_HARTS-1:0] halted_nxt;
   logic [NUM_HARTS-1:0] hpass_nxt;
   logic                 accept;
   logic                 all_halted;
   logic [63:0]          pop;
   logic [CNT_W-1:0]     cyc_inc;
   logic [CNT_W-1:0]     ret_inc;

   assign accept = start && (state == IDLE || state == DONE);

   for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
      hart_halt_detector #(.XLEN(XLEN), .LOOP_LIMIT(LOOP_LIMIT)) u_det (
         .dclk         (dclk),
         .dreset_n     (dreset_n),
         .clear        (accept),
         .enable       (state == RUN),
         .retire_valid (retire_valid[h]),
         .retire_pc    (retire_pc[h*XLEN +: XLEN]),
         .retire_ecall (retire_ecall[h]),
         .retire_a0    (retire_a0[h*XLEN +: XLEN]),
         .halted       (halted[h]),
         .halted_nxt   (halted_nxt[h]),
         .pass_nxt     (hpass_nxt[h])
      );
   end

   // Retires from already-halted harts are not counted.
   always_comb begin
      pop = '0;
      for (int h = 0; h < NUM_HARTS; h++) pop = pop + 64'(retire_valid[h] & ~halted[h]);
      all_halted = &halted_nxt;
      cyc_inc    = CNT_W'(sat_add(64'(cycle_count), 64'd1, CNT_W));
      ret_inc    = CNT_W'(sat_add(64'(retire_count), pop, CNT_W));
   end

   always_ff @(posedge dclk or negedge dreset_n) begin
      if (!dreset_n) begin
         state        <= IDLE;
         tmr          <= '0;
         core_rst_n   <= 1'b0;
         running      <= 1'b0;
         done         <= 1'b0;
         pass         <= 1'b0;
         timeout      <= 1'b0;
         cycle_count  <= '0;
         retire_count <= '0;
      end else begin
         case (state)
            IDLE, DONE: if (start) begin
               state        <= RST;
               tmr          <= TW'(RST_CYCLES - 1);
               done         <= 1'b0;
               pass         <= 1'b0;
               timeout      <= 1'b0;
               cycle_count  <= '0;
               retire_count <= '0;
            end
            RST: if (tmr == '0) begin
               state      <= RUN;
               core_rst_n <= 1'b1;
               running    <= 1'b1;
            end else begin
               tmr <= tmr - 1'b1;
            end
            RUN: begin
               cycle_count  <= cyc_inc;
               retire_count <= ret_inc;
               // A halt completing on the budget's last cycle takes priority over timeout.
               if (all_halted) begin
                  running <= 1'b0;
                  if (DRAIN_CYCLES == 0) begin
                     state      <= DONE;
                     core_rst_n <= 1'b0;
                     done       <= 1'b1;
                     pass       <= &hpass_nxt;
                  end else begin
                     state <= DRAIN;
                     tmr   <= TW'(DRAIN_LOAD);
                  end
               end else if (cyc_inc == CNT_W'(MAX_CYCLES)) begin
                  state      <= DONE;
                  running    <= 1'b0;
                  core_rst_n <= 1'b0;
                  done       <= 1'b1;
                  timeout    <= 1'b1;
                  pass       <= 1'b0;
               end
            end
            DRAIN: if (tmr == '0) begin
               state      <= DONE;
               core_rst_n <= 1'b0;
               done       <= 1'b1;
               pass       <= &hpass_nxt;
            end else begin
               tmr <= tmr - 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pipe_run_controller.sv
// Randomized bench for pipe_run_controller with two harts and a behavioural halt/count model.
module tb_pipe_run_controller;
   localparam int XLEN = 32, NH = 2, RSTC = 2, MAXC = 400, LOOPL = 8, DRAINC = 5, CW = 32;
   localparam int M_ECALL = 0, M_LOOP = 1, M_TMO = 2, M_DUAL = 3, M_SIM = 4, M_ABORT = 5;

   logic                 dclk = 1'b0;
   logic                 dreset_n = 1'b0;
   logic                 start = 1'b0;
   logic [NH-1:0]        rv = '0;
   logic [NH-1:0]        re = '0;
   logic [NH*XLEN-1:0]   rpc = '0;
   logic [NH*XLEN-1:0]   ra0 = '0;
   logic                 core_rst_n, running, done, pass, timeout;
   logic [CW-1:0]        cycle_count, retire_count;

   pipe_run_controller #(
      .XLEN(XLEN), .NUM_HARTS(NH), .RST_CYCLES(RSTC), .MAX_CYCLES(MAXC),
      .LOOP_LIMIT(LOOPL), .DRAIN_CYCLES(DRAINC), .CNT_W(CW)
   ) dut (
      .dclk(dclk), .dreset_n(dreset_n), .start(start),
      .retire_valid(rv), .retire_pc(rpc), .retire_ecall(re), .retire_a0(ra0),
      .core_rst_n(core_rst_n), .running(running), .done(done), .pass(pass),
      .timeout(timeout), .cycle_count(cycle_count), .retire_count(retire_count)
   );

   always #5 dclk = ~dclk;

   int n_chk = 0;
   int n_pass = 0;

   // model: per-hart halt status, same-PC run length, and total counted retires
   bit [NH-1:0]  mh, mp, mhave;
   int           mrun [NH];
   logic [31:0]  mlast [NH];
   longint       mret;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic drive(input int h, input bit v, input logic [31:0] pc, input bit e,
                        input logic [31:0] a0);
      rv[h] = v;
      re[h] = e;
      rpc[h*XLEN +: XLEN] = pc;
      ra0[h*XLEN +: XLEN] = a0;
      if (v && !mh[h]) begin
         mret++;
         if (mhave[h] && pc == mlast[h]) mrun[h]++;
         else mrun[h] = 1;
         mlast[h] = pc;
         mhave[h] = 1'b1;
         if (e || mrun[h] == LOOPL) begin
            mh[h] = 1'b1;
            mp[h] = (a0 == 0);
         end
      end
   endtask

   task automatic gen(input int mode, input int c);
      bit v;
      logic [31:0] pcv;
      case (mode)
         M_DUAL, M_SIM: begin
            int t0, t1;
            t0 = (mode == M_DUAL) ? 10 : MAXC;
            t1 = (mode == M_DUAL) ? 30 : MAXC;
            drive(0, 1'b1, 32'h300 + 32'(4*c), c == t0, (c == t0) ? 32'd0 : ($urandom | 32'd1));
            drive(1, 1'b1, 32'h2000 + 32'(4*c), c == t1, (c == t1) ? 32'd0 : ($urandom | 32'd1));
         end
         default: begin
            if (c == 1) drive(1, 1'b1, 32'h1000, 1'b1, 32'd0);
            else drive(1, 1'($urandom), $urandom, 1'($urandom), $urandom);
            if (mode == M_ECALL) begin
               drive(0, 1'b1, 32'h100 + 32'(4*c), c == 20, (c == 20) ? 32'd0 : ($urandom | 32'd1));
            end else if (mode == M_LOOP) begin
               pcv = (c <= 16 && (c % 2) == 0) ? 32'h44 : 32'h40;
               drive(0, 1'b1, pcv, 1'b0, 32'd1);
            end else begin
               v = 1'($urandom);
               drive(0, v, 32'h100 + 32'(4*c), v ? 1'b0 : 1'($urandom), $urandom);
            end
         end
      endcase
   endtask

   task automatic do_run(input int mode);
      int  c;
      bit  all_h, tmo;
      mh = '0; mp = '0; mhave = '0; mret = 0;
      for (int h = 0; h < NH; h++) begin mrun[h] = 0; mlast[h] = '0; end

      start = 1'b1;
      @(posedge dclk); #1;
      start = 1'b0;
      chk("rst_core_rst_n", core_rst_n, 0);
      chk("rst_cycle_count", cycle_count, 0);
      chk("rst_retire_count", retire_count, 0);
      chk("rst_done", done, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_pass", pass, 0);
      @(posedge dclk); #1;
      chk("rst_hold_core_rst_n", core_rst_n, 0);
      @(posedge dclk); #1;
      chk("run_entry_core_rst_n", core_rst_n, 1);
      chk("run_entry_running", running, 1);

      c = 0; all_h = 1'b0; tmo = 1'b0;
      while (!all_h && !tmo) begin
         c++;
         gen(mode, c);
         if (mode == M_ABORT && c == 50) begin
            #3 dreset_n = 1'b0;
            #1;
            chk("abort_running", running, 0);
            chk("abort_core_rst_n", core_rst_n, 0);
            chk("abort_cycle_count", cycle_count, 0);
            chk("abort_retire_count", retire_count, 0);
            chk("abort_done", done, 0);
            @(posedge dclk); #1;
            chk("abort_hold_running", running, 0);
            rv = '0; re = '0;
            dreset_n = 1'b1;
            @(posedge dclk); #1;
            chk("abort_idle_core_rst_n", core_rst_n, 0);
            return;
         end
         @(posedge dclk); #1;
         all_h = &mh;
         tmo = !all_h && c == MAXC;
         chk("cycle_count", cycle_count, c);
         chk("retire_count", retire_count, mret);
         if (!all_h && !tmo) chk("running", running, 1);
      end

      if (all_h) begin
         chk("drain_running", running, 0);
         chk("drain_core_rst_n", core_rst_n, 1);
         for (int i = 1; i < DRAINC; i++) begin
            rv = NH'($urandom); re = NH'($urandom);
            @(posedge dclk); #1;
            chk("drain_done", done, 0);
            chk("drain_core_rst_n", core_rst_n, 1);
            chk("drain_retire_count", retire_count, mret);
         end
         @(posedge dclk); #1;
      end
      rv = '0; re = '0;
      chk("done", done, 1);
      chk("pass", pass, (&mp) && !tmo);
      chk("timeout", timeout, tmo);
      chk("done_core_rst_n", core_rst_n, 0);
      chk("done_running", running, 0);
      chk("done_cycle_count", cycle_count, c);
      chk("done_retire_count", retire_count, mret);

      rv = NH'($urandom);
      @(posedge dclk); #1;
      rv = '0;
      chk("hold_done", done, 1);
      chk("hold_pass", pass, (&mp) && !tmo);
      chk("hold_cycle_count", cycle_count, c);
      chk("hold_retire_count", retire_count, mret);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      dreset_n = 1'b0;
      repeat (5) @(posedge dclk);
      #1;
      chk("reset_core_rst_n", core_rst_n, 0);
      chk("reset_done", done, 0);
      chk("reset_running", running, 0);
      chk("reset_cycle_count", cycle_count, 0);
      chk("reset_retire_count", retire_count, 0);
      dreset_n = 1'b1;
      @(posedge dclk); #1;
      chk("idle_core_rst_n", core_rst_n, 0);

      do_run(M_ECALL);
      do_run(M_LOOP);
      do_run(M_TMO);
      do_run(M_DUAL);
      do_run(M_SIM);
      do_run(M_ABORT);
      do_run(M_ECALL);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
